led_sweeper: RTL and testbench

LED_SWEEPER -- requirements
Module: led_sweeper

---
 rtl/led_sweeper.sv | 123 ++++++++++++
 tb/tb_led_sweeper.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/led_sweeper.sv
// One-hot LED sweeper: the active lane dwells at lane 0, then sweeps up and either
// bounces back down or wraps to lane 0. A prescaler sets how many enabled cycles make one tick.
module led_sweeper #(
  parameter  int WIDTH = 8,
  parameter  int DWELL = 5,
  parameter  int DIV   = 1,
  localparam int PW    = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic [PW-1:0]    pos,
  output logic             dir,
  output logic             cycle_done
);

  typedef enum logic [1:0] {
    ST_DWELL = 2'd0,
    ST_UP    = 2'd1,
    ST_DOWN  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [15:0]      pre, pre_n;
  logic [7:0]       dwell_cnt, dwell_n;
  logic [PW-1:0]    pos_n;
  logic [WIDTH-1:0] count_n;
  logic             dir_n;
  logic             done_n;
  logic             tick;

  assign tick = en && (pre == 16'(DIV - 1));

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_n = state;
    pos_n   = pos;
    dwell_n = dwell_cnt;
    done_n  = 1'b0;
    pre_n   = pre;

    if (en) pre_n = tick ? 16'd0 : pre + 16'd1;

    if (tick) begin
      case (state)
        ST_DWELL: begin
          if (dwell_cnt == 8'(DWELL - 1)) begin
            state_n = ST_UP;
            pos_n   = PW'(1);
            dwell_n = 8'd0;
          end else begin
            dwell_n = dwell_cnt + 8'd1;
          end
        end
        ST_UP: begin
          if (pos == PW'(WIDTH - 1)) begin
            // A two-lane bounce has no interior lanes to walk back through.
            if (mode || (WIDTH == 2)) begin
              state_n = ST_DWELL;
              pos_n   = '0;
              done_n  = 1'b1;
            end else begin
              state_n = ST_DOWN;
              pos_n   = PW'(WIDTH - 2);
            end
          end else begin
            pos_n = pos + PW'(1);
          end
        end
        ST_DOWN: begin
          if (pos == PW'(1)) begin
            state_n = ST_DWELL;
            pos_n   = '0;
            done_n  = 1'b1;
          end else begin
            pos_n = pos - PW'(1);
          end
        end
        default: begin
          state_n = ST_DWELL;
          pos_n   = '0;
          dwell_n = 8'd0;
        end
      endcase
    end

    count_n = {{(WIDTH-1){1'b0}}, 1'b1} << pos_n;
    dir_n   = (state_n == ST_DOWN);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_DWELL;
      pre        <= 16'd0;
      dwell_cnt  <= 8'd0;
      pos        <= '0;
      count      <= {{(WIDTH-1){1'b0}}, 1'b1};
      dir        <= 1'b0;
      cycle_done <= 1'b0;
    end else if (restart) begin
      state      <= ST_DWELL;
      pre        <= 16'd0;
      dwell_cnt  <= 8'd0;
      pos        <= '0;
      count      <= {{(WIDTH-1){1'b0}}, 1'b1};
      dir        <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      state      <= state_n;
      pre        <= pre_n;
      dwell_cnt  <= dwell_n;
      pos        <= pos_n;
      count      <= count_n;
      dir        <= dir_n;
      cycle_done <= done_n;
    end
  end

endmodule

// File: tb/tb_led_sweeper.sv
// Directed bench for led_sweeper: four parameterisations exercised one at a time,
// outputs sampled 1 time unit after each rising edge against hand-computed vectors.
module tb_led_sweeper;

  logic clk = 1'b0;
  logic reset;
  logic e0, r0, m0, e1, r1, m1, e2, r2, m2, e3, r3, m3;

  logic [7:0] c0;  logic [2:0] p0;  logic d0, k0;
  logic [3:0] c1;  logic [1:0] p1;  logic d1, k1;
  logic [7:0] c2;  logic [2:0] p2;  logic d2, k2;
  logic [1:0] c3;  logic [0:0] p3;  logic d3, k3;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  led_sweeper u_def (.clk(clk), .reset(reset), .en(e0), .restart(r0), .mode(m0),
                     .count(c0), .pos(p0), .dir(d0), .cycle_done(k0));
  led_sweeper #(.WIDTH(4), .DWELL(1)) u_wrap (.clk(clk), .reset(reset), .en(e1), .restart(r1),
                     .mode(m1), .count(c1), .pos(p1), .dir(d1), .cycle_done(k1));
  led_sweeper #(.DIV(3)) u_div (.clk(clk), .reset(reset), .en(e2), .restart(r2), .mode(m2),
                     .count(c2), .pos(p2), .dir(d2), .cycle_done(k2));
  led_sweeper #(.WIDTH(2), .DWELL(2)) u_w2 (.clk(clk), .reset(reset), .en(e3), .restart(r3),
                     .mode(m3), .count(c3), .pos(p3), .dir(d3), .cycle_done(k3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic chk_def(input string tag, input int p, input bit d, input bit k);
    check({tag, ".pos"},   32'(p0), 32'(p));
    check({tag, ".count"}, 32'(c0), 32'(1) << p);
    check({tag, ".dir"},   32'(d0), 32'(d));
    check({tag, ".done"},  32'(k0), 32'(k));
  endtask

  // Default-parameter bounce period, value after each of edges 1..18.
  int def_pos[18] = '{0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};

  initial begin
    reset = 1'b1;
    {e0, r0, m0, e1, r1, m1, e2, r2, m2, e3, r3, m3} = '0;
    #12 reset = 1'b0;

    // Reset state, defaults in bounce mode over two full periods.
    chk_def("rst_def", 0, 1'b0, 1'b0);
    check("rst_wrap.count", 32'(c1), 32'h1);
    check("rst_w2.count",   32'(c3), 32'h1);
    e0 = 1'b1;
    for (int k = 0; k < 36; k++) begin
      step();
      chk_def($sformatf("bounce[%0d]", k + 1), def_pos[k % 18],
              (k % 18) >= 11 && (k % 18) <= 16, (k % 18) == 17);
    end
    e0 = 1'b0;

    // WIDTH=4, DWELL=1, wrap mode.
    pulse_reset();
    e1 = 1'b1; m1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("wrap[%0d].pos", k),   32'(p1), 32'(k % 4));
      check($sformatf("wrap[%0d].count", k), 32'(c1), 32'(1) << (k % 4));
      check($sformatf("wrap[%0d].dir", k),   32'(d1), 32'(0));
      check($sformatf("wrap[%0d].done", k),  32'(k1), 32'((k % 4) == 0));
    end
    e1 = 1'b0;

    // DIV=3: each tick takes three enabled cycles; 15 edges to leave dwell.
    pulse_reset();
    e2 = 1'b1;
    for (int k = 1; k <= 14; k++) step();
    check("div.pos@14", 32'(p2), 32'(0));
    step();
    check("div.pos@15", 32'(p2), 32'(1));
    step();
    check("div.pos@16", 32'(p2), 32'(1));
    e2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("div.frozen.pos",   32'(p2), 32'(1));
      check("div.frozen.count", 32'(c2), 32'h2);
      check("div.frozen.done",  32'(k2), 32'(0));
    end
    e2 = 1'b1;
    step();
    check("div.resume1.pos", 32'(p2), 32'(1));
    step();
    check("div.resume2.pos", 32'(p2), 32'(2));
    step(); step();
    check("div.hold.pos", 32'(p2), 32'(2));
    step();
    check("div.next.pos", 32'(p2), 32'(3));
    e2 = 1'b0;

    // Mode toggled to wrap mid-UP, then back to bounce during dwell.
    pulse_reset();
    e0 = 1'b1; m0 = 1'b0;
    for (int k = 0; k < 7; k++) step();
    chk_def("tog.at3", 3, 1'b0, 1'b0);
    m0 = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk_def("tog.top", 7, 1'b0, 1'b0);
    step();
    chk_def("tog.wrapped", 0, 1'b0, 1'b1);
    m0 = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk_def("tog.dwell_end", 0, 1'b0, 1'b0);
    step();
    chk_def("tog.up1", 1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) step();
    chk_def("tog.top2", 7, 1'b0, 1'b0);
    step();
    chk_def("tog.bounced", 6, 1'b1, 1'b0);

    // Asynchronous reset at pos 5 in DOWN.
    pulse_reset();
    for (int k = 0; k < 13; k++) step();
    chk_def("ar.down5", 5, 1'b1, 1'b0);
    #3 reset = 1'b1;
    #1;
    chk_def("ar.async", 0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk_def("ar.dwell_full", 0, 1'b0, 1'b0);
    step();
    chk_def("ar.up1", 1, 1'b0, 1'b0);
    step(); step();
    chk_def("ar.up3", 3, 1'b0, 1'b0);

    // Synchronous restart while disabled.
    e0 = 1'b0; r0 = 1'b1;
    #2;
    chk_def("rs.before_edge", 3, 1'b0, 1'b0);
    step();
    chk_def("rs.after_edge", 0, 1'b0, 1'b0);
    r0 = 1'b0; e0 = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk_def("rs.dwell_full", 0, 1'b0, 1'b0);
    step();
    chk_def("rs.up1", 1, 1'b0, 1'b0);
    e0 = 1'b0;

    // WIDTH=2, DWELL=2, bounce mode never enters DOWN.
    pulse_reset();
    e3 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("w2[%0d].pos", k),   32'(p3), 32'((k % 3) == 2));
      check($sformatf("w2[%0d].count", k), 32'(c3), ((k % 3) == 2) ? 32'h2 : 32'h1);
      check($sformatf("w2[%0d].dir", k),   32'(d3), 32'(0));
      check($sformatf("w2[%0d].done", k),  32'(k3), 32'((k % 3) == 0));
    end
    e3 = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
